// File: rtl/debug_pkg.sv
// Shared serialiser definitions for the debug UART path: state encoding, default bit period, frame length.
package debug_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int DEFAULT_CLK_PER_BIT = 100;
  localparam int FRAME_BITS          = 10;

  function automatic int frame_cycles(input int clk_per_bit);
    return FRAME_BITS * clk_per_bit;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; head is valid on dout whenever empty is low.
// Write/read take effect on the clock edge; writes while full and reads while empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         din,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   fill
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      fill_nxt;
  logic             wr_ok;
  logic             rd_ok;

  // full is a register, so a read in the same cycle never frees a slot for that cycle's write
  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;
  assign empty = (fill == '0);
  assign dout  = mem[rd_ptr];

  always_comb begin
    fill_nxt = fill;
    if (wr_ok && !rd_ok)
      fill_nxt = fill + 1'b1;
    else if (!wr_ok && rd_ok)
      fill_nxt = fill - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
      full   <= 1'b0;
    end else begin
      if (wr_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok)
        rd_ptr <= rd_ptr + 1'b1;
      fill <= fill_nxt;
      full <= (fill_nxt == FULL_CNT);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok)
      mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/debug_uart_tx.sv
// Buffered 8N1 UART transmitter feeding the AVR; first start bit appears 2 cycles after a write to an idle block.
// tx_busy holds off the upstream writer when the FIFO is full; tx_block (synchronised) gates only frame starts.
module debug_uart_tx
  import debug_pkg::*;
#(
  parameter int CLK_PER_BIT = DEFAULT_CLK_PER_BIT,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    tx_data,
  input  logic                          new_tx_data,
  output logic                          tx_busy,
  input  logic                          tx_block,
  output logic                          tx,
  output logic [$clog2(FIFO_DEPTH):0]   fill,
  output logic                          overflow
);

  localparam int CW = $clog2(CLK_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_PER_BIT - 1);
  localparam logic [2:0]    IDX_LAST = 3'(FRAME_BITS - 3);

  tx_state_t     state;
  logic [CW-1:0] bit_cnt;
  logic [CW-1:0] bit_cnt_nxt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic [7:0]    head;
  logic          block_meta;
  logic          block_s;
  logic          fifo_full;
  logic          fifo_empty;
  logic          bit_done;
  logic          pop;

  assign bit_done    = (bit_cnt == CNT_LAST);
  assign bit_cnt_nxt = bit_done ? '0 : bit_cnt + 1'b1;
  assign pop         = !fifo_empty && !block_s && ((state == IDLE) || ((state == STOP) && bit_done));
  assign tx_busy     = fifo_full;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .wr_en (new_tx_data),
    .din   (tx_data),
    .rd_en (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .fill  (fill)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      block_meta <= 1'b0;
      block_s    <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      block_meta <= tx_block;
      block_s    <= block_meta;
      if (new_tx_data && fifo_full)
        overflow <= 1'b1;
    end
  end

  // tx is registered from the current state, so the line trails the FSM by one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx      <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          tx      <= 1'b1;
          bit_cnt <= '0;
          if (pop) begin
            shift <= head;
            state <= START;
          end
        end
        START: begin
          tx      <= 1'b0;
          bit_cnt <= bit_cnt_nxt;
          if (bit_done) begin
            bit_idx <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          tx      <= shift[0];
          bit_cnt <= bit_cnt_nxt;
          if (bit_done) begin
            shift   <= {1'b0, shift[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == IDX_LAST)
              state <= STOP;
          end
        end
        STOP: begin
          tx      <= 1'b1;
          bit_cnt <= bit_cnt_nxt;
          if (bit_done) begin
            if (pop) begin
              shift <= head;
              state <= START;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/debug_uart_tx.md
# debug_uart_tx

Buffered UART transmitter that sits directly downstream of the terminal debugging block. It accepts message bytes on the `tx_data`/`new_tx_data`/`tx_busy` handshake and queues them in a small FIFO. It then serialises them 8N1 onto the AVR's serial RX pin, honouring the AVR's `tx_block` flow-control line so that no bytes are lost while the AVR's USB buffer is full.

## Interface
- `CLK_PER_BIT`, 100: clock cycles per UART bit (50 MHz / 500 kbaud); must be ≥ 2.
- `FIFO_DEPTH`, 16: byte FIFO depth; must be a power of two, ≥ 2.
- `clk` in 1: system clock; the block uses one clock only.
- `rst` in 1: synchronous, active-high reset.
- `tx_data` in 8: byte to send; valid only while `new_tx_data` is high.
- `new_tx_data` in 1: one-cycle write strobe.
- `tx_busy` out 1: FIFO full; the upstream block must not strobe while this is high.
- `tx_block` in 1: AVR flow control, asynchronous; high means do not start a new frame.
- `tx` out 1: serial line to the AVR; idles high.
- `fill` out $clog2(FIFO_DEPTH)+1: current FIFO occupancy.
- `overflow` out 1: sticky flag; set when a strobe arrives while the FIFO is full.

## Operation
- **Write:** a byte is written when `new_tx_data` && !`tx_busy`.
  - A strobe while full drops the byte and sets `overflow`.
  - `overflow` is cleared only by `rst`.
- **Flow control:** `tx_block` passes through a 2-flop synchroniser to become `block_s`. All decisions use `block_s`.
- **Serialiser FSM:** states IDLE, START, DATA, STOP. A bit counter (0..CLK_PER_BIT-1) and a bit index (0..7) drive it.
  - **IDLE:** `tx`=1. If the FIFO is non-empty and `block_s`=0, pop the head into the shift register and go to START.
  - **START:** `tx`=0 for CLK_PER_BIT cycles, then go to DATA with index 0.
  - **DATA:** `tx`=shift[0] for CLK_PER_BIT cycles per bit, LSB first. Shift after each bit. After bit 7, go to STOP.
  - **STOP:** `tx`=1 for CLK_PER_BIT cycles. On the last cycle, if the FIFO is non-empty and `block_s`=0, pop and go directly to START (no idle gap). Otherwise go to IDLE.
- **Frame abort:** a frame already started always completes, even if `block_s` rises mid-frame. `block_s` gates only frame starts.
- **Reset values:** `tx`=1, `tx_busy`=0, `fill`=0, `overflow`=0, FSM=IDLE, FIFO pointers=0.
  - Reset mid-frame aborts the frame: `tx` is high after the reset edge, and the FIFO contents are discarded.
- **Width rules:**
  - FIFO pointers are $clog2(FIFO_DEPTH) bits and wrap naturally.
  - `fill` is one bit wider so it can represent full (= FIFO_DEPTH).
  - A simultaneous write and pop leaves `fill` unchanged.

## Timing
- `tx_busy` is registered (`fill`==FIFO_DEPTH) with no combinational path from `new_tx_data`.
  - A pop in the same cycle as a full-state strobe does not admit the byte; the byte is dropped and `overflow` is set.
- **Latency:** strobe sampled at edge 0 with the FIFO empty, FSM in IDLE and `block_s`=0. Pop and START entry occur at edge 1; `tx` is low from edge 2.
- **Frame length:** exactly 10×CLK_PER_BIT cycles. Back-to-back frames are 10×CLK_PER_BIT apart, start to start.
- **`tx_block` latency:** 2 cycles of synchroniser delay. A frame may start up to 2 cycles after `tx_block` rises.
- `tx` is driven from a register with no glitches.

## Structure
- **Shared package `debug_pkg`:** serialiser state encoding (IDLE/START/DATA/STOP, 2 bits), the default CLK_PER_BIT, and the frame length constant.
- **Sub-module `sync_fifo`:** generic single-clock FIFO (WIDTH, DEPTH) with ports `wr_en`, `din`, `rd_en`, `dout`, `full`, `empty`, `fill`. It is first-word-fall-through so the head is valid whenever `empty`=0.
- **`debug_uart_tx` itself:** the synchroniser, the FSM/counters, and the `overflow` flag.

## Test plan
- **Single byte:** CLK_PER_BIT=4; write 0x41 into an empty FIFO.
  - `tx` goes low 2 cycles after the strobe.
  - Bits 1,0,0,0,0,0,1,0 follow at 4 cycles each, then a stop bit.
  - The frame totals 40 cycles; `fill` returns to 0.
- **Back-to-back:** write 0x55 and 0xAA on consecutive cycles.
  - The two frames are contiguous, 40 cycles apart with no idle cycle.
  - The decoded bytes are 0x55 then 0xAA.
- **Full/overflow:** hold `tx_block`=1; write 17 bytes.
  - `tx_busy` is high after the 16th write; the 17th byte is dropped and `overflow`=1.
  - Release the block: 16 frames are sent in order; `overflow` stays 1.
- **Block mid-frame:** raise `tx_block` during the DATA bits of frame 1 with 3 bytes queued.
  - Frame 1 completes; no new start bit occurs while the block is held.
  - After release, the remaining bytes are sent within 3 cycles plus the synchroniser delay.
- **Reset mid-frame:** assert `rst` for 1 cycle during bit 3 with 5 bytes queued.
  - `tx`=1 next cycle; `fill`=0, `overflow`=0, `tx_busy`=0.
  - No further frames are sent.
- **Full 64-byte debug message:** drive the upstream-style strobe/busy handshake at default parameters.
  - All 64 bytes arrive in order; the final byte is 0x0D; `overflow` stays 0.
